// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand-forwarding scoreboard that sits beside the ID/EX -> EX
// boundary. It tracks DEPTH in-flight results past EX and resolves NUM_SRC
// source operands, including the ecall a7 read. It also raises load-use stalls
// for loads whose data has not yet returned.

// Per-slot resolver: picks the youngest matching in-flight entry for one source.
module fwd_src_resolve #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 3,
   parameter int SEL_W = 2
) (
   input  logic                       src_en,
   input  logic [4:0]                 src_addr,
   input  logic [XLEN-1:0]            src_rf_data,
   input  logic [DEPTH:1]             ent_vld,
   input  logic [DEPTH:1]             ent_wr,
   input  logic [DEPTH:1]             ent_rdy,
   input  logic [DEPTH:1][4:0]        ent_rd,
   input  logic [DEPTH:1][XLEN-1:0]   ent_data,
   output logic [SEL_W-1:0]           sel,
   output logic [XLEN-1:0]            data,
   output logic                       stall_req
);

   // Scan from the oldest entry to the youngest so the youngest match overwrites.
   // Only the winner's ready bit decides the stall; older unready copies are shadowed.
   always_comb begin
      sel       = '0;
      data      = src_rf_data;
      stall_req = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (src_en && (src_addr != 5'd0) && ent_vld[k] && ent_wr[k] &&
             (ent_rd[k] == src_addr)) begin
            sel       = SEL_W'(k);
            data      = ent_data[k];
            stall_req = ~ent_rdy[k];
         end
      end
   end

endmodule

module fwd_scoreboard #(
   parameter int  XLEN    = 32,
   parameter int  DEPTH   = 3,
   parameter int  NUM_SRC = 3,
   localparam int SEL_W   = $clog2(DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      advance,
   input  logic                      ex_valid,
   input  logic [4:0]                ex_rd,
   input  logic                      ex_reg_write,
   input  logic                      ex_is_load,
   input  logic [XLEN-1:0]           ex_result,
   input  logic                      mem_load_valid,
   input  logic [XLEN-1:0]           mem_load_data,
   input  logic [NUM_SRC*5-1:0]      src_addr,
   input  logic [NUM_SRC-1:0]        src_en,
   input  logic [NUM_SRC*XLEN-1:0]   src_rf_data,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic [NUM_SRC*XLEN-1:0]   fwd_data,
   output logic                      load_use_stall,
   output logic                      protocol_err
);

   // Entry state; index 1 is the EX/MEM (youngest) entry.
   logic [DEPTH:1]            vld_pipe;
   logic [DEPTH:1]            wr_q;
   logic [DEPTH:1]            ld_q;
   logic [DEPTH:1]            rdy_q;
   logic [DEPTH:1][4:0]       rd_q;
   logic [DEPTH:1][XLEN-1:0]  data_q;

   logic [NUM_SRC-1:0]        slot_stall;
   logic                      ld_pending;
   logic                      ld_done;
   logic                      ex_vld_in;

   // Stage-1 load still waiting on memory, and whether it completes this cycle.
   assign ld_pending = vld_pipe[1] & ld_q[1] & ~rdy_q[1];
   assign ld_done    = ld_pending & mem_load_valid;

   // A stalled EX instruction enters as a bubble.
   assign load_use_stall = |slot_stall;
   assign ex_vld_in      = ex_valid & ~load_use_stall;

   // One resolver per source slot.
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
      fwd_src_resolve #(
         .XLEN  (XLEN),
         .DEPTH (DEPTH),
         .SEL_W (SEL_W)
      ) u_res (
         .src_en      (src_en[i]),
         .src_addr    (src_addr[i*5 +: 5]),
         .src_rf_data (src_rf_data[i*XLEN +: XLEN]),
         .ent_vld     (vld_pipe),
         .ent_wr      (wr_q),
         .ent_rdy     (rdy_q),
         .ent_rd      (rd_q),
         .ent_data    (data_q),
         .sel         (fwd_sel[i*SEL_W +: SEL_W]),
         .data        (fwd_data[i*XLEN +: XLEN]),
         .stall_req   (slot_stall[i])
      );
   end

   // Shift entries on advance; otherwise only complete a pending load in place.
   // Load data arriving together with advance lands in the shifted stage-2 copy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld_pipe     <= '0;
         wr_q         <= '0;
         ld_q         <= '0;
         rdy_q        <= '0;
         rd_q         <= '0;
         data_q       <= '0;
         protocol_err <= 1'b0;
      end else if (advance) begin
         for (int k = DEPTH; k >= 2; k--) begin
            vld_pipe[k] <= vld_pipe[k-1];
            wr_q[k]     <= wr_q[k-1];
            ld_q[k]     <= ld_q[k-1];
            rd_q[k]     <= rd_q[k-1];
            if (k == 2 && ld_done) begin
               rdy_q[k]  <= 1'b1;
               data_q[k] <= mem_load_data;
            end else begin
               rdy_q[k]  <= rdy_q[k-1];
               data_q[k] <= data_q[k-1];
            end
         end
         vld_pipe[1] <= ex_vld_in;
         wr_q[1]     <= ex_reg_write;
         ld_q[1]     <= ex_is_load;
         rd_q[1]     <= ex_rd;
         rdy_q[1]    <= ~ex_is_load;
         data_q[1]   <= ex_result;
         // An unready load moving on without its data is a pipeline-control bug.
         if (ld_pending && !mem_load_valid)
            protocol_err <= 1'b1;
      end else if (ld_done) begin
         rdy_q[1]  <= 1'b1;
         data_q[1] <= mem_load_data;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expectations are queued as stimulus is
// applied and drained against the combinational outputs away from the clock edge.
module tb_fwd_scoreboard;

   localparam int XLEN    = 32;
   localparam int NUM_SRC = 3;
   localparam int SEL_W   = 2;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      advance;
   logic                      ex_valid;
   logic [4:0]                ex_rd;
   logic                      ex_reg_write;
   logic                      ex_is_load;
   logic [XLEN-1:0]           ex_result;
   logic                      mem_load_valid;
   logic [XLEN-1:0]           mem_load_data;
   logic [NUM_SRC*5-1:0]      src_addr;
   logic [NUM_SRC-1:0]        src_en;
   logic [NUM_SRC*XLEN-1:0]   src_rf_data;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic [NUM_SRC*XLEN-1:0]   fwd_data;
   logic                      load_use_stall;
   logic                      protocol_err;

   fwd_scoreboard dut (
      .clk            (clk),
      .reset          (reset),
      .advance        (advance),
      .ex_valid       (ex_valid),
      .ex_rd          (ex_rd),
      .ex_reg_write   (ex_reg_write),
      .ex_is_load     (ex_is_load),
      .ex_result      (ex_result),
      .mem_load_valid (mem_load_valid),
      .mem_load_data  (mem_load_data),
      .src_addr       (src_addr),
      .src_en         (src_en),
      .src_rf_data    (src_rf_data),
      .fwd_sel        (fwd_sel),
      .fwd_data       (fwd_data),
      .load_use_stall (load_use_stall),
      .protocol_err   (protocol_err)
   );

   always #5 clk = ~clk;

   // kind: 0..2 select of slot, 3..5 data of slot, 6 stall, 7 protocol_err
   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic logic [31:0] observe(int kind);
      if (kind < 3)       return 32'(fwd_sel[kind*SEL_W +: SEL_W]);
      else if (kind < 6)  return fwd_data[(kind-3)*XLEN +: XLEN];
      else if (kind == 6) return 32'(load_use_stall);
      else                return 32'(protocol_err);
   endfunction

   task automatic push(input string tag, input int kind, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.kind = kind; e.exp = exp;
      q.push_back(e);
   endtask

   task automatic check_q();
      exp_t        e;
      logic [31:0] obs;
      #1;
      while (q.size() > 0) begin
         e   = q.pop_front();
         obs = observe(e.kind);
         n_chk++;
         assert (obs === e.exp) n_pass++;
         else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
   endtask

   task automatic set_src(input int s, input logic [4:0] a, input logic en, input logic [31:0] rf);
      src_addr[s*5 +: 5]       = a;
      src_en[s]                = en;
      src_rf_data[s*XLEN +: XLEN] = rf;
   endtask

   // One advancing cycle with the given EX instruction.
   task automatic step_adv(input logic v, input logic [4:0] rd, input logic ld, input logic [31:0] res);
      ex_valid = v; ex_rd = rd; ex_reg_write = 1'b1; ex_is_load = ld; ex_result = res;
      advance = 1'b1;
      @(posedge clk); #1;
      advance = 1'b0; ex_valid = 1'b0; mem_load_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk); #1;
      mem_load_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; advance = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_reg_write = 1'b0;
      ex_is_load = 1'b0; ex_result = '0; mem_load_valid = 1'b0; mem_load_data = '0;
      src_addr = '0; src_en = '0; src_rf_data = '0;
      set_src(0, 5'd5, 1'b1, 32'h11);
      set_src(1, 5'd6, 1'b1, 32'h22);
      set_src(2, 5'd17, 1'b1, 32'h33);
      #1;
      // reset state
      push("rst_sel0", 0, 0); push("rst_sel1", 1, 0); push("rst_sel2", 2, 0);
      push("rst_dat0", 3, 32'h11); push("rst_dat2", 5, 32'h33);
      push("rst_stall", 6, 0); push("rst_perr", 7, 0);
      check_q();
      @(negedge clk) reset = 1'b1;

      // back-to-back ALU hazard, tracked through every stage
      set_src(1, 5'd0, 1'b0, 0); set_src(2, 5'd0, 1'b0, 0);
      step_adv(1'b1, 5'd5, 1'b0, 32'd7);
      set_src(0, 5'd5, 1'b1, 32'd0);
      push("alu_s1_sel", 0, 1); push("alu_s1_dat", 3, 7); push("alu_s1_stall", 6, 0);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      push("alu_s2_sel", 0, 2); push("alu_s2_dat", 3, 7);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      push("alu_s3_sel", 0, 3); push("alu_s3_dat", 3, 7);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      push("alu_gone_sel", 0, 0); push("alu_gone_dat", 3, 0);
      check_q();

      // priority: youngest wins; x0 never forwards
      step_adv(1'b1, 5'd5, 1'b0, 32'd1);
      step_adv(1'b1, 5'd5, 1'b0, 32'd2);
      set_src(1, 5'd0, 1'b1, 32'h55);
      push("prio_sel", 0, 1); push("prio_dat", 3, 2);
      push("x0_sel", 1, 0); push("x0_dat", 4, 32'h55);
      check_q();
      step_adv(1'b1, 5'd0, 1'b0, 32'hDEAD);
      push("x0_wr_sel", 1, 0); push("x0_wr_dat", 4, 32'h55);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      step_adv(1'b0, 5'd0, 1'b0, 0);
      set_src(1, 5'd0, 1'b0, 0);

      // load-use with 3-cycle memory
      step_adv(1'b1, 5'd6, 1'b1, 32'hBAD0);
      set_src(0, 5'd6, 1'b1, 32'h0);
      push("ld_c1_stall", 6, 1); push("ld_c1_sel", 0, 1);
      check_q();
      idle_cycle();
      push("ld_c2_stall", 6, 1);
      check_q();
      idle_cycle();
      mem_load_valid = 1'b1; mem_load_data = 32'hABCD;
      push("ld_c3_stall", 6, 1);
      check_q();
      idle_cycle();
      push("ld_done_stall", 6, 0); push("ld_done_sel", 0, 1);
      push("ld_done_dat", 3, 32'hABCD); push("ld_done_perr", 7, 0);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      push("ld_s2_sel", 0, 2); push("ld_s2_dat", 3, 32'hABCD);
      check_q();

      // data arriving on the advance cycle lands in stage 2; stalled EX becomes a bubble
      step_adv(1'b1, 5'd8, 1'b1, 32'hBAD1);
      set_src(0, 5'd8, 1'b1, 32'h0);
      push("bub_pre_stall", 6, 1);
      check_q();
      mem_load_valid = 1'b1; mem_load_data = 32'h1234;
      step_adv(1'b1, 5'd9, 1'b0, 32'd99);
      set_src(1, 5'd9, 1'b1, 32'h77);
      push("adv_ld_sel", 0, 2); push("adv_ld_dat", 3, 32'h1234);
      push("adv_ld_stall", 6, 0); push("adv_ld_perr", 7, 0);
      push("bubble_sel", 1, 0); push("bubble_dat", 4, 32'h77);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      step_adv(1'b0, 5'd0, 1'b0, 0);

      // slot disable and ecall a7 read
      step_adv(1'b1, 5'd17, 1'b0, 32'd93);
      step_adv(1'b1, 5'd3, 1'b0, 32'd44);
      set_src(0, 5'd3, 1'b1, 32'h0);
      set_src(1, 5'd3, 1'b0, 32'h66);
      set_src(2, 5'd17, 1'b1, 32'h0);
      push("en_s0_sel", 0, 1); push("en_s0_dat", 3, 44);
      push("dis_s1_sel", 1, 0); push("dis_s1_dat", 4, 32'h66);
      push("ecall_sel", 2, 2); push("ecall_dat", 5, 93);
      check_q();
      step_adv(1'b0, 5'd0, 1'b0, 0);
      step_adv(1'b0, 5'd0, 1'b0, 0);
      set_src(1, 5'd0, 1'b0, 0); set_src(2, 5'd0, 1'b0, 0);

      // protocol error, then asynchronous reset mid-cycle
      step_adv(1'b1, 5'd10, 1'b1, 32'hBAD2);
      step_adv(1'b0, 5'd0, 1'b0, 0);
      set_src(0, 5'd10, 1'b1, 32'h0);
      push("perr_set", 7, 1); push("perr_sel", 0, 2); push("perr_stall", 6, 1);
      check_q();
      idle_cycle();
      push("perr_hold", 7, 1);
      check_q();
      #1 reset = 1'b0;
      push("arst_perr", 7, 0); push("arst_sel0", 0, 0);
      push("arst_stall", 6, 0); push("arst_dat0", 3, 0);
      check_q();
      @(negedge clk) reset = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
